// File: rtl/iter_alu_if.sv
// Operand/result bundle for iter_alu: request side (start, control, A, B)
// and response side (result, zero, busy, done, dbz).
interface iter_alu_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [3:0]       control;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic [WIDTH-1:0] result;
    logic             zero;
    logic             busy;
    logic             done;
    logic             dbz;

    // Requester: drives operands and start, observes results.
    modport master (
        output start, control, A, B,
        input  result, zero, busy, done, dbz
    );

    // ALU side.
    modport slave (
        input  start, control, A, B,
        output result, zero, busy, done, dbz
    );
endinterface

// File: rtl/iter_alu.sv
// iter_alu: single-cycle logic/arithmetic on 4-bit control codes 0000-0111,
// plus iterative unsigned MUL/MULHU/DIVU/REMU (codes 1000-1011) that take
// WIDTH RUN cycles followed by a one-cycle DONE pulse.
module iter_alu #(
    parameter int WIDTH = 32
) (
    input  logic        clk,
    input  logic        reset,
    iter_alu_if.slave   bus
);
    localparam int SW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;

    // Latched operation: r_op[1] selects divide, r_op[0] selects the upper
    // half (MULHU) / remainder (REMU) as the final result.
    logic [1:0]       r_op;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_acc;   // product high half / partial remainder
    logic [WIDTH-1:0] r_mq;    // multiplier -> product low half / dividend -> quotient
    logic [SW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_rr;
    logic             r_dbz;

    logic             w_mc;
    logic             w_accept;
    logic             w_last;
    logic             w_busy;
    logic             w_done;

    logic [WIDTH:0]   w_madd;
    logic [WIDTH-1:0] w_mul_acc;
    logic [WIDTH-1:0] w_mul_mq;
    logic [WIDTH:0]   w_shift;
    logic [WIDTH:0]   w_diff;
    logic             w_ge;
    logic [WIDTH-1:0] w_div_acc;
    logic [WIDTH-1:0] w_div_mq;
    logic [WIDTH-1:0] w_step_acc;
    logic [WIDTH-1:0] w_step_mq;
    logic [WIDTH-1:0] w_final;

    logic [SW-1:0]    w_shamt;
    logic             w_slt;
    logic [WIDTH-1:0] w_comb;
    logic [WIDTH-1:0] w_result;

    assign w_mc     = (bus.control[3:2] == 2'b10);
    assign w_accept = (r_state == S_IDLE) && bus.start && w_mc;
    assign w_last   = (r_cnt == SW'(WIDTH - 1));

    // Shift-add multiply step: add multiplicand when the current multiplier
    // bit is set, then shift {acc, mq} right by one; after WIDTH steps
    // {acc, mq} holds the full 2*WIDTH product.
    assign w_madd    = {1'b0, r_acc} + (r_mq[0] ? {1'b0, r_b} : '0);
    assign w_mul_acc = w_madd[WIDTH:1];
    assign w_mul_mq  = {w_madd[0], r_mq[WIDTH-1:1]};

    // Restoring divide step: shift the next dividend bit into the partial
    // remainder and subtract the divisor if it fits. With B==0 every
    // subtract succeeds, which yields quotient all-ones and remainder A.
    assign w_shift   = {r_acc, r_mq[WIDTH-1]};
    assign w_diff    = w_shift - {1'b0, r_b};
    assign w_ge      = ~w_diff[WIDTH];
    assign w_div_acc = w_ge ? w_diff[WIDTH-1:0] : w_shift[WIDTH-1:0];
    assign w_div_mq  = {r_mq[WIDTH-2:0], w_ge};

    assign w_step_acc = r_op[1] ? w_div_acc : w_mul_acc;
    assign w_step_mq  = r_op[1] ? w_div_mq  : w_mul_mq;
    assign w_final    = r_op[0] ? w_step_acc : w_step_mq;

    // State register.
    always_ff @(posedge clk) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_state_nxt;
    end

    // Next-state and handshake outputs.
    always_comb begin
        w_state_nxt = r_state;
        w_busy      = 1'b0;
        w_done      = 1'b0;
        case (r_state)
            S_IDLE: if (w_accept) w_state_nxt = S_RUN;
            S_RUN: begin
                w_busy = 1'b1;
                if (w_last) w_state_nxt = S_DONE;
            end
            S_DONE: begin
                w_done      = 1'b1;
                w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Iterative datapath: latch operands on accept, step in RUN, and load
    // the result register on the final step so it is valid alongside done.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_op  <= '0;
            r_b   <= '0;
            r_acc <= '0;
            r_mq  <= '0;
            r_cnt <= '0;
            r_rr  <= '0;
            r_dbz <= 1'b0;
        end else if (w_accept) begin
            r_op  <= bus.control[1:0];
            r_b   <= bus.B;
            r_acc <= '0;
            r_mq  <= bus.A;
            r_cnt <= '0;
            r_dbz <= 1'b0;
        end else if (r_state == S_RUN) begin
            r_acc <= w_step_acc;
            r_mq  <= w_step_mq;
            r_cnt <= r_cnt + SW'(1);
            if (w_last) begin
                r_rr  <= w_final;
                r_dbz <= r_op[1] && (r_b == '0);
            end
        end
    end

    assign w_shamt = bus.B[SW-1:0];
    assign w_slt   = ($signed(bus.A) < $signed(bus.B));

    // Single-cycle operations; unused codes read as zero.
    always_comb begin
        w_comb = '0;
        case (bus.control)
            4'b0000: w_comb = bus.A & bus.B;
            4'b0001: w_comb = bus.A | bus.B;
            4'b0010: w_comb = bus.A + bus.B;
            4'b0110: w_comb = bus.A - bus.B;
            4'b0011: w_comb = bus.A ^ bus.B;
            4'b0111: w_comb = {{(WIDTH-1){1'b0}}, w_slt};
            4'b0100: w_comb = bus.A << w_shamt;
            4'b0101: w_comb = bus.A >> w_shamt;
            default: w_comb = '0;
        endcase
    end

    assign w_result   = w_mc ? r_rr : w_comb;
    assign bus.result = w_result;
    assign bus.zero   = (w_result == '0);
    assign bus.busy   = w_busy;
    assign bus.done   = w_done;
    assign bus.dbz    = r_dbz;
endmodule

// File: tb/tb_iter_alu.sv
// Self-checking bench for iter_alu: a cycle-level behavioural model of the
// 32-bit instance checked every cycle, directed literal cases, randomized
// traffic, and a short directed pass on an 8-bit instance.
module tb_iter_alu;
    localparam int W = 32;

    logic clk = 1'b0;
    logic rst;
    int   n_chk = 0;
    int   n_err = 0;
    bit   chk_on = 1'b0;

    always #5 clk = ~clk;

    iter_alu_if #(.WIDTH(W)) bus32 ();
    iter_alu_if #(.WIDTH(8)) bus8 ();

    iter_alu #(.WIDTH(W)) dut (.clk(clk), .reset(rst), .bus(bus32));
    iter_alu #(.WIDTH(8)) dut8 (.clk(clk), .reset(rst), .bus(bus8));

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s got %h want %h", nm, act, exp);
        end
    endtask

    function automatic bit is_mc(input logic [3:0] c);
        return (c >= 4'd8) && (c <= 4'd11);
    endfunction

    function automatic logic [31:0] ref_comb(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
        case (c)
            4'd0: return a & b;
            4'd1: return a | b;
            4'd2: return a + b;
            4'd6: return a - b;
            4'd3: return a ^ b;
            4'd7: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            4'd4: return a << b[4:0];
            4'd5: return a >> b[4:0];
            default: return 32'd0;
        endcase
    endfunction

    function automatic logic [31:0] ref_mc(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] p;
        p = {32'd0, a} * {32'd0, b};
        case (c)
            4'd8:  return p[31:0];
            4'd9:  return p[63:32];
            4'd10: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    // Model: m_p counts cycles since acceptance (0 = idle, 1..W busy, W+1 done).
    int          m_p = 0;
    logic [31:0] m_rr = '0;
    logic [31:0] m_pend = '0;
    logic        m_dbz = 1'b0;
    logic        m_pdbz = 1'b0;

    always @(posedge clk) begin
        if (rst) begin
            m_p   <= 0;
            m_rr  <= '0;
            m_dbz <= 1'b0;
        end else if (m_p == 0) begin
            if (bus32.start && is_mc(bus32.control)) begin
                m_p    <= 1;
                m_dbz  <= 1'b0;
                m_pend <= ref_mc(bus32.control, bus32.A, bus32.B);
                m_pdbz <= bus32.control[1] && (bus32.B == 0);
            end
        end else if (m_p == W) begin
            m_p   <= W + 1;
            m_rr  <= m_pend;
            m_dbz <= m_pdbz;
        end else if (m_p == W + 1) begin
            m_p <= 0;
        end else begin
            m_p <= m_p + 1;
        end
    end

    // Every-cycle comparison of the 32-bit instance against the model.
    always @(negedge clk) begin
        logic [31:0] er;
        if (chk_on) begin
            er = is_mc(bus32.control) ? m_rr : ref_comb(bus32.control, bus32.A, bus32.B);
            chk("busy", 64'(bus32.busy), 64'(m_p >= 1 && m_p <= W));
            chk("done", 64'(bus32.done), 64'(m_p == W + 1));
            chk("dbz", 64'(bus32.dbz), 64'(m_dbz));
            chk("result", 64'(bus32.result), 64'(er));
            chk("zero", 64'(bus32.zero), 64'(er == 0));
        end
    end

    task automatic run32(input logic [3:0] ctl, input logic [31:0] a, input logic [31:0] b,
                         input bit scramble, input bit mid_start,
                         output logic [31:0] res, output int lat, output logic d);
        bit got = 1'b0;
        @(posedge clk); #1;
        bus32.start = 1'b1; bus32.control = ctl; bus32.A = a; bus32.B = b;
        @(posedge clk); #1;
        bus32.start = 1'b0;
        if (scramble) begin bus32.A = $urandom; bus32.B = $urandom; end
        lat = 0;
        while (!got && lat < 100) begin
            @(negedge clk);
            lat++;
            if (mid_start && lat == 5) begin
                bus32.start = 1'b1; bus32.A = $urandom; bus32.B = $urandom;
            end
            if (mid_start && lat == 6) bus32.start = 1'b0;
            if (bus32.done) got = 1'b1;
        end
        if (!got) chk("done_timeout32", 64'd0, 64'd1);
        res = bus32.result;
        d   = bus32.dbz;
    endtask

    task automatic run8(input logic [3:0] ctl, input logic [7:0] a, input logic [7:0] b,
                        output logic [7:0] res, output int lat, output logic d);
        bit got = 1'b0;
        @(posedge clk); #1;
        bus8.start = 1'b1; bus8.control = ctl; bus8.A = a; bus8.B = b;
        @(posedge clk); #1;
        bus8.start = 1'b0; bus8.A = 8'h5A; bus8.B = 8'hC3;
        lat = 0;
        while (!got && lat < 50) begin
            @(negedge clk);
            lat++;
            if (bus8.done) got = 1'b1;
        end
        if (!got) chk("done_timeout8", 64'd0, 64'd1);
        res = bus8.result;
        d   = bus8.dbz;
    endtask

    initial begin
        logic [31:0] r;
        logic [7:0]  r8;
        logic        d;
        int          lat;
        int          ndone;

        rst = 1'b1;
        bus32.start = 1'b0; bus32.control = 4'd0; bus32.A = '0; bus32.B = '0;
        bus8.start = 1'b0;  bus8.control = 4'd0;  bus8.A = '0;  bus8.B = '0;

        chk("pin_mulhu", 64'(ref_mc(4'd9, 32'h0001_0000, 32'h0001_0000)), 64'd1);
        chk("pin_remu0", 64'(ref_mc(4'd11, 32'd123, 32'd0)), 64'd123);

        @(posedge clk); @(posedge clk); #1;
        chk_on = 1'b1;
        bus32.control = 4'b1000;
        @(negedge clk);
        chk("rst_busy", 64'(bus32.busy), 64'd0);
        chk("rst_done", 64'(bus32.done), 64'd0);
        chk("rst_dbz", 64'(bus32.dbz), 64'd0);
        chk("rst_rr", 64'(bus32.result), 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        // Combinational cases
        bus32.control = 4'b0110; bus32.A = 32'd5; bus32.B = 32'd5; #1;
        chk("sub_res", 64'(bus32.result), 64'd0);
        chk("sub_zero", 64'(bus32.zero), 64'd1);
        bus32.control = 4'b0111; bus32.A = 32'hFFFF_FFFF; bus32.B = 32'd1; #1;
        chk("slt_res", 64'(bus32.result), 64'd1);

        // Multiply
        run32(4'b1000, 32'h0001_0000, 32'h0001_0000, 1'b0, 1'b0, r, lat, d);
        chk("mul_res", 64'(r), 64'd0);
        chk("mul_zero", 64'(bus32.zero), 64'd1);
        chk("mul_lat", 64'(lat), 64'd33);
        run32(4'b1001, 32'h0001_0000, 32'h0001_0000, 1'b0, 1'b0, r, lat, d);
        chk("mulhu_res", 64'(r), 64'd1);

        // Divide with operands changing during RUN
        run32(4'b1010, 32'd100, 32'd7, 1'b1, 1'b0, r, lat, d);
        chk("divu_res", 64'(r), 64'd14);
        run32(4'b1011, 32'd100, 32'd7, 1'b1, 1'b0, r, lat, d);
        chk("remu_res", 64'(r), 64'd2);
        chk("remu_dbz", 64'(d), 64'd0);

        // Divide by zero
        run32(4'b1010, 32'd123, 32'd0, 1'b0, 1'b0, r, lat, d);
        chk("divz_res", 64'(r), 64'hFFFF_FFFF);
        chk("divz_dbz", 64'(d), 64'd1);
        chk("divz_lat", 64'(lat), 64'd33);
        run32(4'b1011, 32'd123, 32'd0, 1'b0, 1'b0, r, lat, d);
        chk("remz_res", 64'(r), 64'd123);
        chk("remz_dbz", 64'(d), 64'd1);
        @(posedge clk); #1;
        bus32.start = 1'b1; bus32.control = 4'b1010; bus32.A = 32'd10; bus32.B = 32'd3;
        @(posedge clk); #1;
        bus32.start = 1'b0;
        @(negedge clk);
        chk("dbz_clear", 64'(bus32.dbz), 64'd0);
        chk("dbz_clear_busy", 64'(bus32.busy), 64'd1);
        ndone = 0;
        while (!bus32.done && ndone < 100) begin @(negedge clk); ndone++; end
        chk("div10_3", 64'(bus32.result), 64'd3);

        // start during RUN ignored, then back-to-back, then start in DONE ignored
        run32(4'b1000, 32'd7, 32'd9, 1'b0, 1'b1, r, lat, d);
        chk("midstart_res", 64'(r), 64'd63);
        chk("midstart_lat", 64'(lat), 64'd33);
        run32(4'b1010, 32'd1000, 32'd10, 1'b0, 1'b0, r, lat, d);
        chk("b2b_res", 64'(r), 64'd100);
        chk("b2b_lat", 64'(lat), 64'd33);
        bus32.start = 1'b1; bus32.A = $urandom; bus32.B = $urandom;
        @(posedge clk); #1;
        bus32.start = 1'b0;
        @(negedge clk);
        chk("donestart_busy", 64'(bus32.busy), 64'd0);
        chk("donestart_rr", 64'(bus32.result), 64'd100);

        // Reset in the middle of RUN
        @(posedge clk); #1;
        bus32.start = 1'b1; bus32.control = 4'b1000; bus32.A = 32'd3; bus32.B = 32'd5;
        @(posedge clk); #1;
        bus32.start = 1'b0;
        repeat (10) @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("midrst_busy", 64'(bus32.busy), 64'd0);
        chk("midrst_done", 64'(bus32.done), 64'd0);
        chk("midrst_rr", 64'(bus32.result), 64'd0);
        ndone = 0;
        repeat (40) begin @(negedge clk); if (bus32.done) ndone++; end
        chk("midrst_nodone", 64'(ndone), 64'd0);

        // Randomized traffic against the model
        for (int i = 0; i < 1500; i++) begin
            @(posedge clk); #1;
            rst = ($urandom_range(0, 299) == 0);
            bus32.control = ($urandom_range(0, 9) < 4) ? 4'(8 + $urandom_range(0, 3))
                                                       : 4'($urandom_range(0, 15));
            bus32.A = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 300)) : $urandom;
            case ($urandom_range(0, 7))
                0: bus32.B = 32'd0;
                1, 2: bus32.B = 32'($urandom_range(1, 40));
                default: bus32.B = $urandom;
            endcase
            bus32.start = ($urandom_range(0, 3) == 0);
        end
        @(posedge clk); #1;
        rst = 1'b0; bus32.start = 1'b0;

        // 8-bit instance
        run8(4'b1000, 8'd15, 8'd17, r8, lat, d);
        chk("w8_mul", 64'(r8), 64'hFF);
        chk("w8_lat", 64'(lat), 64'd9);
        run8(4'b1001, 8'd200, 8'd200, r8, lat, d);
        chk("w8_mulhu", 64'(r8), 64'h9C);
        run8(4'b1010, 8'd200, 8'd9, r8, lat, d);
        chk("w8_divu", 64'(r8), 64'd22);
        run8(4'b1011, 8'd200, 8'd9, r8, lat, d);
        chk("w8_remu", 64'(r8), 64'd2);
        run8(4'b1011, 8'd77, 8'd0, r8, lat, d);
        chk("w8_remz", 64'(r8), 64'd77);
        chk("w8_dbz", 64'(d), 64'd1);

        @(posedge clk);
        chk_on = 1'b0;
        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end
endmodule

// File: doc/iter_alu.md
Name: iter_alu

Overview:
- Parametrised successor to the datapath ALU; keeps the 4-bit control encoding for single-cycle logic and arithmetic.
- Adds multi-cycle unsigned multiply and divide, run by an internal FSM with a start/busy/done handshake.
- Sits between the A_mux/B_mux outputs and ALUOut; the multicycle control FSM holds its state while busy=1.

Parameters:
WIDTH, 32, datapath width in bits (>=4); also the iteration count of MUL/MULHU/DIVU/REMU.

Ports:
clk  input  1  clock
reset  input  1  synchronous active-high reset
start  input  1  request a multi-cycle op; sampled only in IDLE with a multi-cycle control code
control  input  4  operation select
A  input  WIDTH  operand A
B  input  WIDTH  operand B
result  output  WIDTH  operation result
zero  output  1  (result == 0)
busy  output  1  multi-cycle op in progress
done  output  1  one-cycle pulse, multi-cycle result valid
dbz  output  1  last completed DIVU/REMU had B==0; valid from done until next accepted start

Behaviour:
- Reset is synchronous and active-high on clk.
- Reset values: state=IDLE, busy=0, done=0, dbz=0, internal result register RR=0.
- Reset mid-operation aborts the op; no done pulse is produced.
- Single-cycle codes (combinational, zero latency; start ignored; FSM untouched):
  - 0000 A&B
  - 0001 A|B
  - 0010 A+B
  - 0110 A-B
  - 0011 A^B
  - 0111 SLT, signed A<B giving 1 else 0
  - 0100 A<<B[log2 WIDTH-1:0]
  - 0101 A>>B[...], logical
  - Sums and differences wrap modulo 2^WIDTH.
- Multi-cycle codes:
  - 1000 MUL, low WIDTH bits of A*B
  - 1001 MULHU, high WIDTH bits of unsigned A*B
  - 1010 DIVU, unsigned A/B
  - 1011 REMU, unsigned A%B
- Any other code: result=0 and start is ignored.
- result mux: if control is a multi-cycle code, result=RR; otherwise result is the combinational value. zero follows result in both cases.
- FSM states:
  - IDLE: start=1 with a multi-cycle code latches A, B and control; go to RUN, busy=1, counter=0.
  - RUN: one shift-add (mul) or restoring-subtract (div) step per cycle; counter increments. After step WIDTH-1, go to DONE.
  - DONE: RR loaded, done=1, busy=0; next state IDLE unconditionally.
- Latency: start accepted at edge N; busy=1 for cycles N+1..N+WIDTH; done=1 during cycle N+WIDTH+1; RR is valid from that cycle until the next completion or reset.
- start while in RUN or DONE is ignored; it is not queued.
- A, B and control may change after acceptance without affecting the op; only the latched copies are used.
- Divide by zero: fixed latency is unchanged. DIVU gives RR=all ones, REMU gives RR=A (latched). dbz=1 with done and holds until the next accepted start, which clears it.
- MUL and MULHU use a 2*WIDTH product internally; no overflow flag.
- Back-to-back: start asserted in the cycle after done (state is IDLE) is accepted.

Test Plan:
- WIDTH=32, control=0110, A=5, B=5, no clock -> result=0, zero=1. Same A/B with control=0111 and A=32'hFFFFFFFF, B=1 -> result=1 (signed -1<1).
- MUL: start with A=32'h0001_0000, B=32'h0001_0000 -> busy 32 cycles, done at cycle 33; MUL gives RR=0, zero=1. Rerun as MULHU -> RR=1.
- DIVU with A=100, B=7 -> RR=14. Rerun as REMU -> RR=2, dbz=0. Change A/B during RUN -> same results.
- DIVU with A=123, B=0 -> RR=32'hFFFFFFFF, dbz=1. REMU with A=123, B=0 -> RR=123, dbz=1. Next accepted start clears dbz.
- start pulsed during RUN and again during DONE -> ignored: exactly one done pulse, RR unchanged by the second request. start in the cycle after done -> accepted.
- reset asserted at RUN cycle 10 -> next cycle busy=0, done=0, RR=0, state IDLE; no done pulse follows. WIDTH=8 regression: MUL 15*17 -> RR=8'hFF, latency 9 cycles.
